// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: multi-lane stochastic-to-binary decoder counting 1s over 2^N valid samples.
// Ports: clock, reset (async, active-high), start (open/restart window), bit_valid, bits[LANES],
//        out[(N+1)*LANES] (lane i at [(i+1)*(N+1)-1 : i*(N+1)]), done (one-cycle pulse), busy.
// Option: define SC_DECODER_BIPOLAR_EN for bipolar output 2*count-2^N (saturated at 2^N-1).
module sc_stream_decoder #(
  parameter int N = 12,
  parameter int LANES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     bit_valid,
  input  logic [LANES-1:0]         bits,
  output logic [(N+1)*LANES-1:0]   out,
  output logic                     done,
  output logic                     busy
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nx;
  logic [N:0] cnt [LANES];
  logic [N:0] tot [LANES];
  logic [N-1:0] smp;
  logic [(N+1)*LANES-1:0] res;
  logic fire;
  assign fire = (state == ACCUM) && bit_valid && (&smp);
  assign busy = (state == ACCUM);
  always_comb begin
    state_nx = state;
    state_nx = start ? ACCUM : fire ? IDLE : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    // Completion commits the count including the final sample's bit.
    assign tot[g] = cnt[g] + (N+1)'(bits[g]);
`ifdef SC_DECODER_BIPOLAR_EN
    // Full count (2^N) would be +2^N, which does not fit; clamp to 2^N-1.
    assign res[g*(N+1) +: N+1] = tot[g][N] ? {1'b0, {N{1'b1}}}
                                           : {tot[g][N-1:0], 1'b0} - {1'b1, {N{1'b0}}};
`else
    assign res[g*(N+1) +: N+1] = tot[g];
`endif
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      smp <= '0;
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
    end else if (start) begin
      smp <= '0;
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
    end else if (state == ACCUM && bit_valid) begin
      smp <= smp + N'(1);
      for (int i = 0; i < LANES; i++) cnt[i] <= tot[i];
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out  <= '0;
      done <= 1'b0;
    end else begin
      done <= fire;
      if (fire) out <= res;
    end
endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder: randomized self-checking bench for sc_stream_decoder with a per-lane count model.
module tb_sc_stream_decoder;
  localparam int N = 12;
  localparam int L = 4;
  localparam int W = N + 1;
  localparam int WIN = 1 << N;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic [L-1:0] bits = '0;
  logic [W*L-1:0] dout;
  logic done;
  logic busy;
  int passed = 0;
  int total = 0;
  int mc [L];
  sc_stream_decoder #(.N(N), .LANES(L)) dut (
    .clock(clock), .reset(reset), .start(start), .bit_valid(bit_valid),
    .bits(bits), .out(dout), .done(done), .busy(busy)
  );
  always #5 clock = ~clock;
  function automatic logic [W-1:0] exp_lane(input int c);
    int v;
`ifdef SC_DECODER_BIPOLAR_EN
    v = (c == WIN) ? WIN - 1 : 2 * c - WIN;
`else
    v = c;
`endif
    return W'(v);
  endfunction
  function automatic logic [W*L-1:0] exp_bus();
    logic [W*L-1:0] r;
    for (int l = 0; l < L; l++) r[l*W +: W] = exp_lane(mc[l]);
    return r;
  endfunction
  function automatic logic [L-1:0] pat_bits(input int pat, input int k);
    logic [L-1:0] r;
    r = (pat == 0) ? '1 : (pat == 1) ? {1'b1, (k % 4) == 0, 1'b0, (k % 2) == 0} : L'($urandom);
    return r;
  endfunction
  task automatic pulse_start();
    start = 1'b1;
    bit_valid = 1'($urandom);
    bits = L'($urandom);
    @(posedge clock); #1;
    start = 1'b0;
    bit_valid = 1'b0;
    for (int l = 0; l < L; l++) mc[l] = 0;
  endtask
  // Drives n valid samples (gaps per duty %), tracking when done is seen relative to samples sent.
  task automatic send(input int n, input int duty, input int pat, input bit start_last,
                      output int first_done, output int ndone);
    int k;
    logic v;
    logic [L-1:0] b;
    k = 0;
    first_done = -1;
    ndone = 0;
    while (k < n) begin
      v = ($urandom_range(99) < duty);
      b = L'($urandom);
      if (v) begin
        b = pat_bits(pat, k);
        for (int l = 0; l < L; l++) mc[l] += int'(b[l]);
        k++;
      end
      bit_valid = v;
      bits = b;
      start = start_last && v && (k == n);
      @(posedge clock); #1;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
    end
    bit_valid = 1'b0;
    start = 1'b0;
  endtask
  task automatic test_reset();
    #12;
    total++; if (dout !== '0) $display("FAIL reset_out: got %h expected 0", dout); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask
  task automatic test_full_window();
    int fd, nd;
    pulse_start();
    total++; if (busy !== 1'b1) $display("FAIL full_busy_rise: got %b expected 1", busy); else passed++;
    send(WIN, 100, 0, 1'b0, fd, nd);
    total++; if (fd !== WIN) $display("FAIL full_done_time: got %0d expected %0d", fd, WIN); else passed++;
    total++; if (nd !== 1) $display("FAIL full_done_count: got %0d expected 1", nd); else passed++;
    for (int l = 0; l < L; l++) begin
      total++;
      if (dout[l*W +: W] !== exp_lane(WIN)) $display("FAIL full_lane%0d: got %h expected %h", l, dout[l*W +: W], exp_lane(WIN));
      else passed++;
    end
    total++; if (busy !== 1'b0) $display("FAIL full_busy_fall: got %b expected 0", busy); else passed++;
    @(posedge clock); #1;
    total++; if (done !== 1'b0) $display("FAIL full_done_pulse: got %b expected 0", done); else passed++;
    total++; if (dout !== exp_bus()) $display("FAIL full_out_hold: got %h expected %h", dout, exp_bus()); else passed++;
  endtask
  task automatic test_patterns();
    int fd, nd;
    pulse_start();
    send(WIN, 100, 1, 1'b0, fd, nd);
    total++; if (fd !== WIN || nd !== 1) $display("FAIL pat_done: got first=%0d n=%0d expected %0d/1", fd, nd, WIN); else passed++;
    for (int l = 0; l < L; l++) begin
      total++;
      if (dout[l*W +: W] !== exp_lane(mc[l])) $display("FAIL pat_lane%0d: got %h expected %h", l, dout[l*W +: W], exp_lane(mc[l]));
      else passed++;
    end
  endtask
  task automatic test_gaps();
    int fd, nd;
    pulse_start();
    send(WIN, 50, 0, 1'b0, fd, nd);
    total++; if (fd !== WIN || nd !== 1) $display("FAIL gap_done: got first=%0d n=%0d expected %0d/1", fd, nd, WIN); else passed++;
    for (int l = 0; l < L; l++) begin
      total++;
      if (dout[l*W +: W] !== exp_lane(WIN)) $display("FAIL gap_lane%0d: got %h expected %h", l, dout[l*W +: W], exp_lane(WIN));
      else passed++;
    end
  endtask
  task automatic test_abort();
    int fd, nd;
    logic [W*L-1:0] prev;
    prev = exp_bus();
    pulse_start();
    send(1000, 100, 2, 1'b0, fd, nd);
    total++; if (nd !== 0) $display("FAIL abort_early_done: got %0d expected 0", nd); else passed++;
    pulse_start();
    total++; if (dout !== prev) $display("FAIL abort_out_hold: got %h expected %h", dout, prev); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL abort_busy: got %b expected 1", busy); else passed++;
    send(WIN, 100, 2, 1'b0, fd, nd);
    total++; if (fd !== WIN || nd !== 1) $display("FAIL abort_done: got first=%0d n=%0d expected %0d/1", fd, nd, WIN); else passed++;
    for (int l = 0; l < L; l++) begin
      total++;
      if (dout[l*W +: W] !== exp_lane(mc[l])) $display("FAIL abort_lane%0d: got %h expected %h", l, dout[l*W +: W], exp_lane(mc[l]));
      else passed++;
    end
  endtask
  task automatic test_back_to_back();
    int fd, nd;
    pulse_start();
    send(WIN, 100, 2, 1'b1, fd, nd);
    total++; if (fd !== WIN || nd !== 1) $display("FAIL b2b_done1: got first=%0d n=%0d expected %0d/1", fd, nd, WIN); else passed++;
    for (int l = 0; l < L; l++) begin
      total++;
      if (dout[l*W +: W] !== exp_lane(mc[l])) $display("FAIL b2b_lane%0d: got %h expected %h", l, dout[l*W +: W], exp_lane(mc[l]));
      else passed++;
    end
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", busy); else passed++;
    for (int l = 0; l < L; l++) mc[l] = 0;
    send(WIN, 100, 2, 1'b0, fd, nd);
    total++; if (fd !== WIN || nd !== 1) $display("FAIL b2b_done2: got first=%0d n=%0d expected %0d/1", fd, nd, WIN); else passed++;
    total++; if (dout !== exp_bus()) $display("FAIL b2b_out2: got %h expected %h", dout, exp_bus()); else passed++;
  endtask
  task automatic test_reset_mid();
    int fd, nd;
    pulse_start();
    send(2000, 100, 2, 1'b0, fd, nd);
    #3 reset = 1'b1;
    #1;
    total++; if (dout !== '0) $display("FAIL rst_mid_out: got %h expected 0", dout); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", done); else passed++;
    #2 reset = 1'b0;
    @(posedge clock); #1;
    for (int l = 0; l < L; l++) mc[l] = 0;
    send(WIN, 100, 0, 1'b0, fd, nd);
    total++; if (nd !== 0) $display("FAIL rst_idle_done: got %0d expected 0", nd); else passed++;
    total++; if (dout !== '0) $display("FAIL rst_idle_out: got %h expected 0", dout); else passed++;
    pulse_start();
    send(WIN, 100, 2, 1'b0, fd, nd);
    total++; if (fd !== WIN || nd !== 1) $display("FAIL rst_new_done: got first=%0d n=%0d expected %0d/1", fd, nd, WIN); else passed++;
    total++; if (dout !== exp_bus()) $display("FAIL rst_new_out: got %h expected %h", dout, exp_bus()); else passed++;
  endtask
  initial begin
    for (int l = 0; l < L; l++) mc[l] = 0;
    test_reset();
    test_full_window();
    test_patterns();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
